// File: rtl/stream_mux_arb.sv
// N-to-1 stream multiplexer with a single registered output stage.
// Channel choice is select-driven (MODE=0) or round-robin (MODE=1).
module stream_mux_arb #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 4,
   parameter int unsigned MODE  = 0,
   localparam int unsigned SW   = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] din,
   input  logic [NCH-1:0]       din_valid,
   output logic [NCH-1:0]       din_ready,
   input  logic [SW-1:0]        select,
   output logic [WIDTH-1:0]     dout,
   output logic [SW-1:0]        dout_ch,
   output logic                 dout_valid,
   input  logic                 dout_ready
);

   logic [WIDTH-1:0] dout_q;
   logic [SW-1:0]    dout_ch_q;
   logic             dout_valid_q;
   logic [SW-1:0]    last_q;

   logic             load_en;
   logic             grant_vld;
   logic [SW-1:0]    grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic             xfer;

   assign load_en = !dout_valid_q || dout_ready;

   always_comb begin
      grant_vld  = 1'b0;
      grant_idx  = '0;
      grant_data = '0;
      if (MODE == 0) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (select == SW'(i) && din_valid[i]) begin
               grant_vld = 1'b1;
               grant_idx = SW'(i);
            end
         end
      end else begin
         // Walk the search order backwards so the earliest candidate wins.
         for (int k = int'(NCH); k >= 1; k--) begin
            if (din_valid[(int'(last_q) + k) % int'(NCH)]) begin
               grant_vld = 1'b1;
               grant_idx = SW'((int'(last_q) + k) % int'(NCH));
            end
         end
      end
      for (int unsigned i = 0; i < NCH; i++) begin
         if (grant_idx == SW'(i)) grant_data = din[i*WIDTH +: WIDTH];
      end
   end

   // rst_n gating keeps inputs blocked while reset is held.
   always_comb begin
      din_ready = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         din_ready[i] = rst_n && load_en && grant_vld && (grant_idx == SW'(i));
      end
   end

   assign xfer = |din_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q       <= '0;
         dout_ch_q    <= '0;
         dout_valid_q <= 1'b0;
         last_q       <= SW'(NCH - 1);
      end else if (xfer) begin
         dout_q       <= grant_data;
         dout_ch_q    <= grant_idx;
         dout_valid_q <= 1'b1;
         if (MODE == 1) last_q <= grant_idx;
      end else if (dout_ready) begin
         dout_valid_q <= 1'b0;
      end
   end

   assign dout       = dout_q;
   assign dout_ch    = dout_ch_q;
   assign dout_valid = dout_valid_q;

endmodule

// File: doc/stream_mux_arb.md
STREAM_MUX_ARB -- requirements
Module: stream_mux_arb

Interface
REQ-001 Parameter WIDTH, default 8: data width of each channel and of the output.
REQ-002 Parameter NCH, default 4, legal range 2..16: number of input channels.
REQ-003 Parameter MODE, default 0: 0 = select-driven channel choice, 1 = round-robin arbitration (select ignored).
REQ-004 Derived SW = clog2(NCH): select and channel-id width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 din  in  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 din_valid  in  NCH  per-channel valid.
REQ-009 din_ready  out  NCH  per-channel ready, combinational.
REQ-010 select  in  SW  channel selection, used only when MODE=0.
REQ-011 dout  out  WIDTH  registered output data.
REQ-012 dout_ch  out  SW  registered index of the channel that supplied dout.
REQ-013 dout_valid  out  1  registered output valid.
REQ-014 dout_ready  in  1  downstream ready.

Function
REQ-015 Output stage: single register; load_en = !dout_valid || dout_ready, giving full throughput of one word per cycle.
REQ-016 Input transfer on channel i: din_valid[i] && din_ready[i] at a rising edge; output transfer: dout_valid && dout_ready.
REQ-017 At most one din_ready bit high per cycle; all bits low when load_en is 0.
REQ-018 MODE=0: grant = select when select < NCH and din_valid[select]=1; otherwise no grant; other channels' valid has no effect.
REQ-019 MODE=1: search starts at (last+1) mod NCH and wraps; grant = first channel with din_valid=1; no grant when all valid bits are low.
REQ-020 din_ready[g] = load_en && grant exists && g == grant.
REQ-021 On input transfer: dout <= din[g], dout_ch <= g, dout_valid <= 1, last <= g (MODE=1 only).
REQ-022 No input transfer and dout_ready=1: dout_valid <= 0; dout and dout_ch hold their values.
REQ-023 No input transfer and dout_ready=0: all output registers hold; dout/dout_ch are stable while dout_valid=1 and not accepted.
REQ-024 Simultaneous output and input transfer in the same cycle: the new word replaces the old one, dout_valid stays 1, no bubble.
REQ-025 Latency: one cycle from input transfer to dout_valid=1.
REQ-026 Round-robin pointer wrap: last=NCH-1 gives first priority to channel 0.
REQ-027 Round-robin fairness: a channel holding valid continuously is granted within NCH accepted words.
REQ-028 A change of select while dout_valid=1 and dout_ready=0 does not alter dout or dout_ch.

Reset
REQ-029 While rst_n=0: dout=0, dout_ch=0, dout_valid=0, last=NCH-1, and din_ready all low (load_en is still 1, but inputs are blocked during reset).
REQ-030 Assertion mid-transfer discards the held word immediately; the first word after deassertion follows REQ-026 priority.
REQ-031 Deassertion is synchronised by the team reset synchroniser outside this block; the block needs no internal deglitching.

Verification
REQ-032 Select sweep: MODE=0, NCH=4, WIDTH=8, din={10,15,ac,03}, all valid, dout_ready=1, select 0,1,2,3 on consecutive cycles -> dout 03,ac,15,10 with dout_ch 0..3, each one cycle later, dout_valid continuously 1.
REQ-033 Backpressure: MODE=0, select=1, dout_ready=0 for 3 cycles after the first capture -> dout=ac held, din_ready=0000; dout_ready=1 -> accepted, and the next word loads in the same cycle.
REQ-034 Round-robin: MODE=1, all four valid, dout_ready=1 for 8 cycles -> dout_ch sequence 0,1,2,3,0,1,2,3.
REQ-035 Sparse round-robin: MODE=1, valid=1010 steady -> dout_ch alternates 1,3,1,3; then valid=0000 -> dout_valid drops one cycle after the last transfer.
REQ-036 Invalid select: MODE=0, NCH=3, select=3 -> din_ready=000, dout_valid stays 0.
REQ-037 Reset mid-operation: rst_n pulsed low while dout_valid=1 and dout_ready=0 -> dout_valid=0, dout=00 immediately (before next edge); after release with MODE=1, the first grant is channel 0.
